// File: rtl/auth_seq_ctrl.sv
// Bluetooth unlock-code authentication and power-enable sequencer.
// It adds rider-off power-down qualification and a lockout after repeated bad code bytes.
module auth_seq_ctrl #(
  parameter int                    CODE_LEN    = 2,
  parameter logic [CODE_LEN*8-1:0] CODE        = 16'h676F,
  parameter logic [7:0]            STOP_BYTE   = 8'h73,
  parameter logic [7:0]            RESUME_BYTE = 8'h67,
  parameter logic [15:0]           OFF_DLY     = 16'd50000,
  parameter int                    MAX_FAIL    = 3,
  parameter logic [23:0]           LOCK_CYC    = 24'd5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  output logic       clr_rx_rdy,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic       locked,
  output logic       auth_fail,
  output logic [1:0] state_dbg
);

  localparam int IDX_W  = $clog2(CODE_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PWR       = 2'd1;
  localparam logic [1:0] STOP_PEND = 2'd2;
  localparam logic [1:0] LOCK      = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [FAIL_W-1:0] fail_cnt, fail_nxt;
  logic [15:0]       off_cnt;
  logic [23:0]       lock_cnt, lock_nxt;
  logic              fail_pulse;
  logic              rider_gone;
  logic [7:0]        code_byte;

  // Handshake: a byte is valid while rx_rdy=1 and is always accepted in that
  // same cycle (clr_rx_rdy=1); the receiver drops rx_rdy on the next edge.
  assign clr_rx_rdy = rx_rdy & ~rst;
  assign rider_gone = rider_off & (off_cnt >= (OFF_DLY - 16'd1));
  assign state_dbg  = state;

  // Expected code byte for the current position; MSB byte arrives first.
  always_comb begin
    code_byte = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (IDX_W'(i) == idx) code_byte = CODE[(CODE_LEN-1-i)*8 +: 8];
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    fail_nxt   = fail_cnt;
    lock_nxt   = lock_cnt;
    fail_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (rx_rdy) begin
          if (rx_data == code_byte) begin
            if (idx == IDX_W'(CODE_LEN - 1)) begin
              state_nxt = PWR;
              idx_nxt   = '0;
              fail_nxt  = '0;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            idx_nxt    = '0;
            fail_pulse = 1'b1;
            fail_nxt   = fail_cnt + 1'b1;
            if (fail_cnt == FAIL_W'(MAX_FAIL - 1)) begin
              state_nxt = LOCK;
              lock_nxt  = LOCK_CYC - 24'd1;
            end
          end
        end
      end
      PWR: begin
        if (rider_gone) state_nxt = IDLE;
        else if (rx_rdy && rx_data == STOP_BYTE) state_nxt = STOP_PEND;
      end
      STOP_PEND: begin
        if (rx_rdy && rx_data == RESUME_BYTE) state_nxt = PWR;
        else if (rider_gone) state_nxt = IDLE;
      end
      default: begin
        if (lock_cnt == 24'd0) begin
          state_nxt = IDLE;
          fail_nxt  = '0;
          idx_nxt   = '0;
        end else begin
          lock_nxt = lock_cnt - 24'd1;
        end
      end
    endcase
    if (state_nxt == IDLE && state != IDLE) idx_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      fail_cnt  <= '0;
      lock_cnt  <= '0;
      off_cnt   <= '0;
      pwr_up    <= 1'b0;
      locked    <= 1'b0;
      auth_fail <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      fail_cnt  <= fail_nxt;
      lock_cnt  <= lock_nxt;
      // Outputs track the next state so they line up with the state register.
      pwr_up    <= (state_nxt == PWR) || (state_nxt == STOP_PEND);
      locked    <= (state_nxt == LOCK);
      auth_fail <= fail_pulse;
      if (!rider_off) off_cnt <= '0;
      else if (off_cnt < (OFF_DLY - 16'd1)) off_cnt <= off_cnt + 16'd1;
    end
  end

endmodule
